// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation
// encodings, FSM states, default width and small op-decode helpers.
package mult_div_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Divide ops have the upper encoding bit set.
  function automatic logic isDivideOp(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops (MULT, DIV) have the lower encoding bit clear.
  function automatic logic isSignedOp(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit. Signed operations run on operand
// magnitudes; the signs are recorded at start and applied in FIX. Multiply
// and divide share one 2*WIDTH working register and one adder/subtractor.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  input  logic             HI_Write,
  input  logic             LO_Write,
  input  logic [WIDTH-1:0] Write_Data,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e             r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_rawA;
  logic [CW-1:0]      r_count;
  logic               r_isDiv;
  logic               r_negResult;
  logic               r_negRem;
  logic               r_divZero;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_startDiv;
  logic               w_startSigned;
  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_addA;
  logic [WIDTH:0]     w_addB;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_accNext;
  logic [2*WIDTH-1:0] w_negAcc;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fixHi;
  logic [WIDTH-1:0]   w_fixLo;

  assign w_startDiv    = isDivideOp(Op);
  assign w_startSigned = isSignedOp(Op);
  assign w_signA       = w_startSigned & Operand_A[WIDTH-1];
  assign w_signB       = w_startSigned & Operand_B[WIDTH-1];
  assign w_absA        = w_signA ? -Operand_A : Operand_A;
  assign w_absB        = w_signB ? -Operand_B : Operand_B;

  // One shared adder: multiply adds the multiplicand into the upper half,
  // divide subtracts the divisor from the shifted partial remainder.
  always_comb begin
    w_addA    = '0;
    w_addB    = '0;
    w_sum     = '0;
    w_accNext = r_acc;
    if (r_isDiv) begin
      w_addA = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_addB = ~{1'b0, r_operand};
      w_sum  = w_addA + w_addB + (WIDTH+1)'(1);
      if (!w_sum[WIDTH]) begin
        w_accNext = {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_accNext = {w_addA[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_addA = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
      w_addB = {1'b0, r_operand};
      w_sum  = w_addA + w_addB;
      if (r_acc[0]) begin
        w_accNext = {w_sum, r_acc[WIDTH-1:1]};
      end else begin
        w_accNext = {w_addA, r_acc[WIDTH-1:1]};
      end
    end
  end

  assign w_negAcc = -r_acc;
  assign w_quot   = r_acc[WIDTH-1:0];
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];

  // Sign correction for the final HI/LO values; the signed-overflow case
  // falls out naturally since the negated magnitude wraps to itself.
  always_comb begin
    w_fixHi = r_acc[2*WIDTH-1:WIDTH];
    w_fixLo = r_acc[WIDTH-1:0];
    if (r_isDiv) begin
      if (r_divZero) begin
        w_fixHi = r_rawA;
        w_fixLo = '1;
      end else begin
        w_fixLo = r_negResult ? -w_quot : w_quot;
        w_fixHi = r_negRem ? -w_rem : w_rem;
      end
    end else if (r_negResult) begin
      w_fixHi = w_negAcc[2*WIDTH-1:WIDTH];
      w_fixLo = w_negAcc[WIDTH-1:0];
    end
  end

  // Control FSM with registered Busy/Done and the HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_operand   <= '0;
      r_rawA      <= '0;
      r_count     <= '0;
      r_isDiv     <= 1'b0;
      r_negResult <= 1'b0;
      r_negRem    <= 1'b0;
      r_divZero   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (HI_Write) begin
            r_hi <= Write_Data;
          end
          if (LO_Write) begin
            r_lo <= Write_Data;
          end
          if (Start) begin
            r_state     <= CALC;
            r_busy      <= 1'b1;
            r_count     <= '0;
            r_isDiv     <= w_startDiv;
            r_rawA      <= Operand_A;
            r_divZero   <= (Operand_B == '0);
            r_negResult <= w_signA ^ w_signB;
            r_negRem    <= w_startDiv & w_signA;
            if (w_startDiv) begin
              r_acc     <= {{WIDTH{1'b0}}, w_absA};
              r_operand <= w_absB;
            end else begin
              r_acc     <= {{WIDTH{1'b0}}, w_absB};
              r_operand <= w_absA;
            end
          end
        end
        CALC: begin
          r_acc   <= w_accNext;
          r_count <= r_count + CW'(1);
          if (r_count == LAST_ITER) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_hi    <= w_fixHi;
          r_lo    <= w_fixLo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: an arithmetic reference model
// feeds a scoreboard queue at Start, and a Done monitor pops and compares.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } result_t;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         Start      = 1'b0;
  logic [1:0]   Op         = 2'b00;
  logic [W-1:0] Operand_A  = '0;
  logic [W-1:0] Operand_B  = '0;
  logic         HI_Write   = 1'b0;
  logic         LO_Write   = 1'b0;
  logic [W-1:0] Write_Data = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;
  result_t sb[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Start(Start),
    .Op(Op),
    .Operand_A(Operand_A),
    .Operand_B(Operand_B),
    .HI_Write(HI_Write),
    .LO_Write(LO_Write),
    .Write_Data(Write_Data),
    .Busy(Busy),
    .Done(Done),
    .HI(HI),
    .LO(LO)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic result_t modelResult(input logic [1:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    result_t r;
    logic [63:0] p;
    p = '0;
    r.hi = '0;
    r.lo = '0;
    case (op)
      OP_MULT: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin
          r.lo = '1;
          r.hi = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          r.lo = 32'h80000000;
          r.hi = 32'h0;
        end else begin
          r.lo = $signed(a) / $signed(b);
          r.hi = $signed(a) % $signed(b);
        end
      end
      default: begin
        if (b == 0) begin
          r.lo = '1;
          r.hi = a;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Called at a falling edge: presents one Start cycle and records the expected result.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    Start     = 1'b1;
    Op        = op;
    Operand_A = a;
    Operand_B = b;
    sb.push_back(modelResult(op, a, b));
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Counts sampled Busy cycles until it drops (bounded) and expects Done then.
  task automatic waitDone(output int busyCycles);
    busyCycles = 0;
    while (Busy && busyCycles < 100) begin
      busyCycles++;
      @(negedge clk);
    end
    checkOutput("doneAfterBusy", {63'b0, Done}, 64'd1);
  endtask

  // Scoreboard monitor: every Done pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    result_t e;
    if (rst_n && Done) begin
      doneCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("sbHI", {32'b0, HI}, {32'b0, e.hi});
        checkOutput("sbLO", {32'b0, LO}, {32'b0, e.lo});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int d0;
    logic [W-1:0] hiBefore;
    logic [1:0] rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetHI", {32'b0, HI}, 64'd0);
    checkOutput("resetLO", {32'b0, LO}, 64'd0);
    checkOutput("resetBusy", {63'b0, Busy}, 64'd0);
    checkOutput("resetDone", {63'b0, Done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] MULT -3 * 5");
    d0 = doneCount;
    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd5);
    waitDone(cycles);
    checkOutput("multBusyCycles", 64'(cycles), 64'd33);
    checkOutput("multHI", {32'b0, HI}, 64'hFFFFFFFF);
    checkOutput("multLO", {32'b0, LO}, 64'hFFFFFFF1);
    @(negedge clk);
    checkOutput("multDoneLow", {63'b0, Done}, 64'd0);
    checkOutput("multDoneOnce", 64'(doneCount - d0), 64'd1);

    $display("[TB] MULTU max * max");
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(cycles);
    checkOutput("multuHI", {32'b0, HI}, 64'hFFFFFFFE);
    checkOutput("multuLO", {32'b0, LO}, 64'h00000001);

    $display("[TB] DIV -7 / 2 then back-to-back DIVU 100 / 0");
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2);
    waitDone(cycles);
    checkOutput("divLO", {32'b0, LO}, 64'hFFFFFFFD);
    checkOutput("divHI", {32'b0, HI}, 64'hFFFFFFFF);
    applyStimulus(OP_DIVU, 32'd100, 32'd0);
    waitDone(cycles);
    checkOutput("b2bBusyCycles", 64'(cycles), 64'd33);
    checkOutput("divZeroLO", {32'b0, LO}, 64'hFFFFFFFF);
    checkOutput("divZeroHI", {32'b0, HI}, 64'h00000064);

    $display("[TB] DIV signed overflow");
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitDone(cycles);
    checkOutput("ovfLO", {32'b0, LO}, 64'h80000000);
    checkOutput("ovfHI", {32'b0, HI}, 64'h0);

    $display("[TB] Start and HI_Write ignored while busy");
    applyStimulus(OP_MULTU, 32'h00012345, 32'h00000100);
    hiBefore = HI;
    repeat (3) @(negedge clk);
    Start      = 1'b1;
    Op         = OP_DIVU;
    Operand_A  = 32'hDEADBEEF;
    Operand_B  = 32'h00000003;
    HI_Write   = 1'b1;
    Write_Data = 32'h00001234;
    @(negedge clk);
    Start    = 1'b0;
    HI_Write = 1'b0;
    checkOutput("hiHeldWhileBusy", {32'b0, HI}, {32'b0, hiBefore});
    checkOutput("stillBusy", {63'b0, Busy}, 64'd1);
    waitDone(cycles);
    checkOutput("ignoreHI", {32'b0, HI}, 64'h0);
    checkOutput("ignoreLO", {32'b0, LO}, 64'h01234500);
    LO_Write   = 1'b1;
    Write_Data = 32'h0000ABCD;
    @(negedge clk);
    LO_Write = 1'b0;
    checkOutput("mtloLO", {32'b0, LO}, 64'h0000ABCD);
    checkOutput("mtloHIHeld", {32'b0, HI}, 64'h0);
    HI_Write   = 1'b1;
    LO_Write   = 1'b1;
    Write_Data = 32'h5A5AA5A5;
    @(negedge clk);
    HI_Write = 1'b0;
    LO_Write = 1'b0;
    checkOutput("bothHI", {32'b0, HI}, 64'h5A5AA5A5);
    checkOutput("bothLO", {32'b0, LO}, 64'h5A5AA5A5);
    repeat (3) @(negedge clk);
    checkOutput("holdHI", {32'b0, HI}, 64'h5A5AA5A5);

    $display("[TB] random back-to-back operations");
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = (i == 3) ? 32'd0 : $urandom();
      if (i == 5) rb = 32'($urandom_range(1, 9));
      applyStimulus(rop, ra, rb);
      waitDone(cycles);
    end

    $display("[TB] reset in the middle of DIVU");
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'd1000, 32'd7);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetHI", {32'b0, HI}, 64'd0);
    checkOutput("midResetLO", {32'b0, LO}, 64'd0);
    checkOutput("midResetBusy", {63'b0, Busy}, 64'd0);
    checkOutput("midResetDone", {63'b0, Done}, 64'd0);
    sb.delete();
    d0 = doneCount;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("noDoneAfterReset", 64'(doneCount - d0), 64'd0);
    checkOutput("idleAfterReset", {63'b0, Busy}, 64'd0);
    applyStimulus(OP_MULTU, 32'd6, 32'd7);
    waitDone(cycles);
    checkOutput("postResetHI", {32'b0, HI}, 64'd0);
    checkOutput("postResetLO", {32'b0, LO}, 64'd42);

    repeat (2) @(negedge clk);
    checkOutput("scoreboardEmpty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
